// File: rtl/cordicfifo_pkg.sv
// rtl/cordicfifo_pkg.sv - shared CORDICFIFO sizing constants and flag helper
package cordicfifo_pkg;

  localparam int C_WIDTH     = 32;
  localparam int C_DEPTH     = 128;
  localparam int C_AW        = 7;
  localparam int C_RD_LAT    = 2;
  localparam int C_AFULL_TH  = 120;
  localparam int C_AEMPTY_TH = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  function automatic fifo_flags_t calc_flags(input logic [31:0] cnt,
                                             input logic [31:0] depth,
                                             input logic [31:0] afull_th,
                                             input logic [31:0] aempty_th);
    fifo_flags_t f;
    f.full   = (cnt == depth);
    f.empty  = (cnt == 32'd0);
    f.afull  = (cnt >= afull_th);
    f.aempty = (cnt <= aempty_th);
    return f;
  endfunction

endpackage

// File: rtl/cordicfifo_rd_pipe.sv
// rtl/cordicfifo_rd_pipe.sv - read-valid delay line matching the RAM read latency
module cordicfifo_rd_pipe
  import cordicfifo_pkg::*;
#(
  parameter int RD_LAT = C_RD_LAT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vld,
  output logic o_vld
);

  logic [RD_LAT-1:0] r_sr;

  generate
    if (RD_LAT == 1) begin : g_one
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sr <= '0;
        else          r_sr <= i_vld;
      end
    end else begin : g_multi
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sr <= '0;
        else          r_sr <= {r_sr[RD_LAT-2:0], i_vld};
      end
    end
  endgenerate

  assign o_vld = r_sr[RD_LAT-1];

endmodule

// File: rtl/cordicfifo_sync_ctrl.sv
// rtl/cordicfifo_sync_ctrl.sv - single-clock FIFO controller for the CORDICFIFO LSRAM wrapper
module cordicfifo_sync_ctrl
  import cordicfifo_pkg::*;
#(
  parameter int WIDTH     = C_WIDTH,
  parameter int DEPTH     = C_DEPTH,
  parameter int AW        = C_AW,
  parameter int RD_LAT    = C_RD_LAT,
  parameter int AFULL_TH  = C_AFULL_TH,
  parameter int AEMPTY_TH = C_AEMPTY_TH
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA,
  input  logic             RE,
  output logic [WIDTH-1:0] Q,
  output logic             DVLD,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [AW:0]      WRCNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [AW-1:0]    RAM_WADDR,
  output logic [AW-1:0]    RAM_RADDR,
  output logic             RAM_WEN,
  output logic             RAM_REN,
  output logic [WIDTH-1:0] RAM_WDATA,
  input  logic [WIDTH-1:0] RAM_RDATA
);

  localparam logic [AW:0] L_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] r_count;
  logic        r_full;
  logic        r_empty;
  logic        r_afull;
  logic        r_aempty;
  logic        r_ovf;
  logic        r_udf;

  logic        w_wr_ok;
  logic        w_rd_ok;
  logic [AW:0] w_count_nxt;
  fifo_flags_t w_flags_nxt;

  // A read while full frees the slot being written, so both are accepted.
  assign w_rd_ok = RE & ~r_empty;
  assign w_wr_ok = WE & (~r_full | (RE & r_full));

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok & ~w_rd_ok)      w_count_nxt = r_count + L_ONE;
    else if (w_rd_ok & ~w_wr_ok) w_count_nxt = r_count - L_ONE;
  end

  assign w_flags_nxt = calc_flags(32'(w_count_nxt), 32'(DEPTH),
                                  32'(AFULL_TH), 32'(AEMPTY_TH));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + L_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + L_ONE;
      r_count  <= w_count_nxt;
      r_full   <= w_flags_nxt.full;
      r_empty  <= w_flags_nxt.empty;
      r_afull  <= w_flags_nxt.afull;
      r_aempty <= w_flags_nxt.aempty;
      r_ovf    <= WE & ~w_wr_ok;
      r_udf    <= RE & ~w_rd_ok;
    end
  end

  cordicfifo_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .i_clk   (CLOCK),
    .i_rst_n (RESET_N),
    .i_vld   (w_rd_ok),
    .o_vld   (DVLD)
  );

  assign RAM_WEN   = w_wr_ok;
  assign RAM_WADDR = r_wptr[AW-1:0];
  assign RAM_WDATA = DATA;
  assign RAM_REN   = w_rd_ok;
  assign RAM_RADDR = r_rptr[AW-1:0];

  assign Q         = RAM_RDATA;
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign AFULL     = r_afull;
  assign AEMPTY    = r_aempty;
  assign WRCNT     = r_count;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_udf;

endmodule
